// File: rtl/float_divider.sv
// Single-precision floating-point divider.
// The mantissa quotient comes from restoring division, one bit per clock, MSB first.
// One extra cycle then normalises, rounds half-up and writes the result register.
// Operands are always treated as normalised; there is no special-value handling.
module float_divider #(
  parameter logic [7:0] EXP_BIAS = 8'd127
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [31:0] Dividend,
  input  logic [31:0] Divisor,
  output logic [31:0] Result,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2
  } state_t;

  state_t      state_r;
  logic        sign_r;
  logic [7:0]  exp_a_r;
  logic [7:0]  exp_b_r;
  logic [23:0] mant_b_r;
  logic [24:0] rem_r;
  logic [25:0] quot_r;
  logic [4:0]  iter_r;

  logic [24:0] trial_s;
  logic        q_bit_s;
  logic [24:0] rem_next_s;
  logic [24:0] sig_s;
  logic [7:0]  adj_s;
  logic        carry_s;
  logic [22:0] frac_s;
  logic [7:0]  exp_s;

  // One restoring-division step: subtract the divisor when it fits, then shift.
  // The remainder stays below twice the divisor, so 25 bits are always enough.
  always_comb begin
    trial_s = rem_r - {1'b0, mant_b_r};
    if (rem_r >= {1'b0, mant_b_r}) begin
      q_bit_s    = 1'b1;
      rem_next_s = trial_s << 1;
    end else begin
      q_bit_s    = 1'b0;
      rem_next_s = rem_r << 1;
    end
  end

  // Normalise the 26-bit raw quotient, round half-up, and form the biased exponent.
  // The rounding carry occurs only when every bit of sig_s is 1. In that case
  // the 23-bit fraction wraps to zero on its own.
  always_comb begin
    if (quot_r[25]) begin
      sig_s = quot_r[25:1];
      adj_s = 8'd0;
    end else begin
      sig_s = quot_r[24:0];
      adj_s = 8'd1;
    end
    carry_s = &sig_s;
    frac_s  = sig_s[23:1] + {22'd0, sig_s[0]};
    exp_s   = exp_a_r - exp_b_r + EXP_BIAS - adj_s + {7'd0, carry_s};
  end

  // Control FSM with the datapath registers and the registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r  <= IDLE;
      sign_r   <= 1'b0;
      exp_a_r  <= 8'd0;
      exp_b_r  <= 8'd0;
      mant_b_r <= 24'd0;
      rem_r    <= 25'd0;
      quot_r   <= 26'd0;
      iter_r   <= 5'd0;
      Result   <= 32'd0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            sign_r   <= Dividend[31] ^ Divisor[31];
            exp_a_r  <= Dividend[30:23];
            exp_b_r  <= Divisor[30:23];
            mant_b_r <= {1'b1, Divisor[22:0]};
            rem_r    <= {1'b0, 1'b1, Dividend[22:0]};
            quot_r   <= 26'd0;
            iter_r   <= 5'd0;
            Busy     <= 1'b1;
            state_r  <= DIVIDE;
          end else begin
            Busy <= 1'b0;
          end
        end
        DIVIDE: begin
          quot_r <= {quot_r[24:0], q_bit_s};
          rem_r  <= rem_next_s;
          if (iter_r == 5'd25) begin
            iter_r  <= 5'd0;
            state_r <= ROUND;
          end else begin
            iter_r <= iter_r + 5'd1;
          end
        end
        ROUND: begin
          Result  <= {sign_r, exp_s, frac_s};
          Busy    <= 1'b0;
          Done    <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          iter_r  <= 5'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/float_divider.md
FLOAT_DIVIDER -- requirements
Module: float_divider

Interface
REQ-001 Parameter EXP_BIAS, default 8'd127, exponent bias added back after subtraction.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 Start  input  1  request; accepted on a rising edge where Start=1 and Busy=0.
REQ-005 Dividend  input  32  IEEE-754 single, numerator; sampled only at accept.
REQ-006 Divisor  input  32  IEEE-754 single, denominator; sampled only at accept.
REQ-007 Result  output  32  quotient; registered; held until next Done.
REQ-008 Busy  output  1  high from the accept edge until the Done edge.
REQ-009 Done  output  1  one-cycle pulse; Result valid while high and after.

Function
REQ-010 States SHALL be IDLE, DIVIDE, ROUND; IDLE->DIVIDE on accept, DIVIDE->ROUND after 26 iterations, ROUND->IDLE after 1 cycle.
REQ-011 At accept the block SHALL latch sign = Dividend[31] XOR Divisor[31], EA, EB, MA = {1,Dividend[22:0]}, MB = {1,Divisor[22:0]}.
REQ-012 DIVIDE SHALL perform restoring division, one quotient bit per cycle, MSB first, giving Qraw = floor(MA*2^25 / MB), 26 bits.
REQ-013 Normalize: Qraw[25]=1 -> sig25 = Qraw[25:1], adj = 0; else sig25 = Qraw[24:0], adj = 1.
REQ-014 Rounding: R = sig25[24:1] + sig25[0] (round-half-up), 25-bit sum; carry C = R[24].
REQ-015 Result[22:0] SHALL be R[22:0] (all zero when C=1).
REQ-016 Result[30:23] SHALL be (EA - EB + EXP_BIAS - adj + C) mod 256; no overflow/underflow saturation.
REQ-017 Result[31] SHALL be the latched sign.
REQ-018 Operands are treated as normalized; zero, denormal, Inf, NaN inputs get no special handling (hidden bit always 1).
REQ-019 Latency: Done SHALL be high in the cycle after the 27th rising edge following the accept edge; Busy falls on that same edge.
REQ-020 Result register SHALL update only on the ROUND->IDLE edge.
REQ-021 Start while Busy=1 SHALL be ignored; no queuing, in-flight operands unaffected.
REQ-022 Start may be accepted in the Done cycle (back-to-back); Busy rises again on that edge, Done falls.
REQ-023 Dividend/Divisor changes after accept SHALL not affect the in-flight result.

Reset
REQ-024 Rst=1 on a rising edge SHALL force IDLE, Result=32'h0, Busy=0, Done=0, iteration counter=0.
REQ-025 Reset mid-DIVIDE or mid-ROUND SHALL abandon the operation; no Done pulse follows.
REQ-026 Rst has priority over Start on the same edge.

Verification
REQ-027 6.0/2.0: 0x40C00000 / 0x40000000 -> Result 0x40400000, Done exactly 27 edges after accept, one cycle wide.
REQ-028 1.0/3.0: 0x3F800000 / 0x40400000 -> 0x3EAAAAAB (round-up path, adj=1).
REQ-029 -8.0/0.5: 0xC1000000 / 0x3F000000 -> 0xC1800000; 1.0/1.0 -> 0x3F800000.
REQ-030 Start pulsed again at edge 10 of an op with different operands -> ignored, first result unchanged, single Done.
REQ-031 Rst asserted at edge 15 of an op -> Busy=0, Result=0 next cycle, no Done; a new op then completes normally.
REQ-032 Back-to-back: Start held high across Done -> second op accepted in Done cycle, second Done 27 edges later, Result matches reference model (REQ-011..017).
